n64_vbus_gen: RTL and testbench

//  Synthetic N64 digital video bus source: emits nDSYNC plus 7-bit muxed data (sync nibble, R, G, B) with
//  N64 timing and a selectable test pattern. Drives the DAC pipeline in place of a console for bring-up,
//  and serves as closed-loop stimulus for the video-info extractor.

---
 rtl/n64_vbus_gen_pkg.sv | 52 +++++
 rtl/n64_vbus_pattern.sv | 48 ++++
 rtl/n64_vbus_gen.sv | 149 ++++++++++++++
 tb/tb_n64_vbus_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/n64_vbus_gen_pkg.sv
// Shared constants, encodings and sync helpers for the synthetic N64 video bus source.
// N64_VBUS_GEN_CSYNC_SERR_EN selects serrated composite sync in csync_level().
package n64_vbus_gen_pkg;

  localparam logic [9:0] H_TOTAL_NTSC = 10'd773;
  localparam logic [9:0] H_TOTAL_PAL  = 10'd794;
  localparam logic [9:0] HS_W         = 10'd57;
  localparam logic [9:0] CLAMP_W      = 10'd34;
  localparam logic [9:0] H_ACT_START  = 10'd128;
  localparam logic [9:0] H_ACT        = 10'd640;
  localparam logic [6:0] BAR_W        = 7'd80;

  localparam logic [8:0] V_ACT_START      = 9'd16;
  localparam logic [8:0] VS_W             = 9'd3;
  localparam logic [8:0] V_ACT_NTSC       = 9'd240;
  localparam logic [8:0] V_ACT_PAL        = 9'd288;
  localparam logic [8:0] V_TOTAL_NTSC_ODD  = 9'd263;
  localparam logic [8:0] V_TOTAL_NTSC_EVEN = 9'd262;
  localparam logic [8:0] V_TOTAL_PAL_ODD   = 9'd313;
  localparam logic [8:0] V_TOTAL_PAL_EVEN  = 9'd312;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_WHITE   = 2'd3
  } pattern_e;

  typedef struct packed {
    logic nvsync;
    logic nclamp;
    logic nhsync;
    logic ncsync;
  } sync_nibble_t;

  function automatic logic csync_level(input logic nhsync, input logic nvsync);
`ifdef N64_VBUS_GEN_CSYNC_SERR_EN
    // hsync pulses flip polarity inside vsync, giving serrations
    return ~(nhsync ^ nvsync);
`else
    return nhsync & nvsync;
`endif
  endfunction

endpackage

// File: rtl/n64_vbus_pattern.sv
// Combinational test-pattern colour for one active pixel; window gating is done by the parent.
module n64_vbus_pattern
  import n64_vbus_gen_pkg::*;
(
  input  logic [6:0] ax,
  input  logic       ay3,
  input  logic [2:0] bar_idx,
  input  logic [1:0] pattern,
  output logic [6:0] r,
  output logic [6:0] g,
  output logic [6:0] b
);

  // Bar order W,Y,C,G,M,R,B,K maps index bits straight onto inverted colour enables.
  always_comb begin
    r = 7'h00;
    g = 7'h00;
    b = 7'h00;
    case (pattern)
      PAT_BARS: begin
        r = bar_idx[1] ? 7'h00 : 7'h7F;
        g = bar_idx[2] ? 7'h00 : 7'h7F;
        b = bar_idx[0] ? 7'h00 : 7'h7F;
      end
      PAT_RAMP: begin
        r = ax;
        g = ax;
        b = ax;
      end
      PAT_CHECKER: begin
        r = (ax[3] ^ ay3) ? 7'h7F : 7'h00;
        g = r;
        b = r;
      end
      PAT_WHITE: begin
        r = 7'h7F;
        g = 7'h7F;
        b = 7'h7F;
      end
      default: begin
        r = 7'h00;
        g = 7'h00;
        b = 7'h00;
      end
    endcase
  end

endmodule

// File: rtl/n64_vbus_gen.sv
// Synthetic N64 digital video bus source: nDSYNC plus muxed sync/R/G/B data with N64 timing.
// Define N64_VBUS_GEN_CSYNC_SERR_EN to emit serrated composite sync on the nCSYNC bit.
module n64_vbus_gen
  import n64_vbus_gen_pkg::*;
(
  input  logic       VCLK,
  input  logic       RST,
  input  logic       pal_i,
  input  logic       i480_i,
  input  logic [1:0] pattern_i,
  output logic       nDSYNC_o,
  output logic [6:0] D_o,
  output logic       sof_o
);

  logic [1:0]   phase_r;
  logic [9:0]   hcnt_r;
  logic [8:0]   vcnt_r;
  logic         odd_r;
  logic         pal_r;
  logic [1:0]   pattern_r;
  logic [6:0]   bar_cnt_r;
  logic [2:0]   bar_idx_r;

  logic [9:0]   h_total_s;
  logic [9:0]   h_half_s;
  logic [8:0]   v_total_s;
  logic [8:0]   v_act_s;
  logic         slot_end_s;
  logic         h_last_s;
  logic         v_last_s;
  logic         nhsync_s;
  logic         nclamp_s;
  logic         nvsync_s;
  sync_nibble_t nib_s;
  logic [9:0]   ax_s;
  logic [8:0]   ay_s;
  logic         active_s;
  logic [6:0]   r_s;
  logic [6:0]   g_s;
  logic [6:0]   b_s;

  assign h_total_s  = pal_r ? H_TOTAL_PAL : H_TOTAL_NTSC;
  assign h_half_s   = h_total_s >> 1;
  assign v_total_s  = pal_r ? (odd_r ? V_TOTAL_PAL_ODD : V_TOTAL_PAL_EVEN)
                            : (odd_r ? V_TOTAL_NTSC_ODD : V_TOTAL_NTSC_EVEN);
  assign v_act_s    = pal_r ? V_ACT_PAL : V_ACT_NTSC;
  assign slot_end_s = (phase_r == PH_B);
  assign h_last_s   = (hcnt_r == (h_total_s - 10'd1));
  assign v_last_s   = (vcnt_r == (v_total_s - 9'd1));

  // Slot/line/field counters; video mode only changes at the field wrap so a frame is never mixed.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      phase_r   <= 2'd0;
      hcnt_r    <= 10'd0;
      vcnt_r    <= 9'd0;
      odd_r     <= 1'b1;
      pal_r     <= pal_i;
      pattern_r <= pattern_i;
    end else begin
      phase_r <= phase_r + 2'd1;
      if (slot_end_s) begin
        if (h_last_s) begin
          hcnt_r    <= 10'd0;
          pattern_r <= pattern_i;
          if (v_last_s) begin
            vcnt_r <= 9'd0;
            pal_r  <= pal_i;
            odd_r  <= ~i480_i | ~odd_r;
          end else begin
            vcnt_r <= vcnt_r + 9'd1;
          end
        end else begin
          hcnt_r <= hcnt_r + 10'd1;
        end
      end
    end
  end

  // Bar index steps every BAR_W slots from the first active slot, avoiding a divider on ax.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      bar_cnt_r <= 7'd0;
      bar_idx_r <= 3'd0;
    end else if (slot_end_s) begin
      if (hcnt_r == (H_ACT_START - 10'd1)) begin
        bar_cnt_r <= 7'd0;
        bar_idx_r <= 3'd0;
      end else if (bar_cnt_r == (BAR_W - 7'd1)) begin
        bar_cnt_r <= 7'd0;
        bar_idx_r <= bar_idx_r + 3'd1;
      end else begin
        bar_cnt_r <= bar_cnt_r + 7'd1;
      end
    end
  end

  // Sync levels; the even field's vsync window is shifted by half a line.
  always_comb begin
    nhsync_s = (hcnt_r >= HS_W);
    nclamp_s = ~((hcnt_r >= HS_W) && (hcnt_r < (HS_W + CLAMP_W)));
    if (odd_r) begin
      nvsync_s = (vcnt_r >= VS_W);
    end else begin
      nvsync_s = ~(((vcnt_r == 9'd0) && (hcnt_r >= h_half_s)) ||
                   ((vcnt_r != 9'd0) && (vcnt_r < VS_W)) ||
                   ((vcnt_r == VS_W) && (hcnt_r < h_half_s)));
    end
  end

  assign nib_s = '{nvsync: nvsync_s, nclamp: nclamp_s, nhsync: nhsync_s,
                   ncsync: csync_level(nhsync_s, nvsync_s)};

  // Unsigned wrap makes positions before the window compare as large values.
  assign ax_s     = hcnt_r - H_ACT_START;
  assign ay_s     = vcnt_r - V_ACT_START;
  assign active_s = (ax_s < H_ACT) && (ay_s < v_act_s);

  n64_vbus_pattern u_pattern (
    .ax      (ax_s[6:0]),
    .ay3     (ay_s[3]),
    .bar_idx (bar_idx_r),
    .pattern (pattern_r),
    .r       (r_s),
    .g       (g_s),
    .b       (b_s)
  );

  // Output register: one VCLK behind the counter state.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      nDSYNC_o <= 1'b1;
      D_o      <= 7'h00;
      sof_o    <= 1'b0;
    end else begin
      nDSYNC_o <= (phase_r != PH_SYNC);
      sof_o    <= (phase_r == PH_SYNC) && (hcnt_r == 10'd0) && (vcnt_r == 9'd0);
      case (phase_r)
        PH_SYNC: D_o <= {3'b000, nib_s};
        PH_R:    D_o <= active_s ? r_s : 7'h00;
        PH_G:    D_o <= active_s ? g_s : 7'h00;
        PH_B:    D_o <= active_s ? b_s : 7'h00;
        default: D_o <= 7'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vbus_gen.sv
// Bench for n64_vbus_gen: linear-position video model compared every cycle, plus literal pins.
module tb_n64_vbus_gen;

  logic       VCLK = 1'b0;
  logic       RST = 1'b1;
  logic       pal_i = 1'b0;
  logic       i480_i = 1'b0;
  logic [1:0] pattern_i = 2'd0;
  logic       nDSYNC_o;
  logic [6:0] D_o;
  logic       sof_o;

  int checks = 0;
  int errors = 0;

  // model: position counted as slots since field start, mode latched per field
  bit         m_live = 1'b0;
  int         m_phase = 0;
  int         m_pos = 0;
  int         m_pat = 0;
  bit         m_pal = 1'b0;
  bit         m_odd = 1'b1;
  bit         e_valid = 1'b0;
  bit         e_rst = 1'b0;
  bit         e_nd = 1'b1;
  bit         e_sof = 1'b0;
  bit         e_pal = 1'b0;
  logic [6:0] e_d = 7'h00;
  int         e_phase = 0;
  int         e_pos = 0;

  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

`ifdef N64_VBUS_GEN_CSYNC_SERR_EN
  logic [3:0] first_nib = 4'b0101;
  logic       cs_1_10 = 1'b1;
`else
  logic [3:0] first_nib = 4'b0100;
  logic       cs_1_10 = 1'b0;
`endif

  // NTSC hand-computed pins: line 16 bars, line 17 ramp, line 18 checker, line 19 white
  int         pin_pos [16] = '{12496, 12496, 12496, 12576, 12576, 12576, 13135, 13135,
                               13135, 12495, 12495, 12495, 13469, 14050, 14042, 14987};
  int         pin_ph  [16] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 3, 2, 2};
  logic [6:0] pin_d   [16] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00,
                               7'h00, 7'h00, 7'h00, 7'h00, 7'h48, 7'h7F, 7'h00, 7'h7F};

  n64_vbus_gen dut (
    .VCLK      (VCLK),
    .RST       (RST),
    .pal_i     (pal_i),
    .i480_i    (i480_i),
    .pattern_i (pattern_i),
    .nDSYNC_o  (nDSYNC_o),
    .D_o       (D_o),
    .sof_o     (sof_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_d(input int phase, input int pos, input bit pal,
                                         input bit odd, input int pat);
    int htot, h, v, ax, ay, vact;
    bit nh, ncl, nv, ncs;
    logic [2:0] rgb;
    logic [6:0] d;
    d = 7'h00;
    htot = pal ? 794 : 773;
    vact = pal ? 288 : 240;
    h = pos % htot;
    v = pos / htot;
    if (phase == 0) begin
      nh  = (h >= 57);
      ncl = !(h >= 57 && h < 91);
      if (odd) nv = !(pos < 3 * htot);
      else     nv = !(pos >= htot / 2 && pos < 3 * htot + htot / 2);
`ifdef N64_VBUS_GEN_CSYNC_SERR_EN
      ncs = (nh == nv);
`else
      ncs = nh && nv;
`endif
      d = {3'b000, nv, ncl, nh, ncs};
    end else if (v >= 16 && v < 16 + vact && h >= 128 && h < 768) begin
      ax = h - 128;
      ay = v - 16;
      case (pat)
        0: begin
          rgb = bars[ax / 80];
          d = rgb[3 - phase] ? 7'h7F : 7'h00;
        end
        1: d = 7'(ax % 128);
        2: d = (((ax / 8) % 2) != ((ay / 8) % 2)) ? 7'h7F : 7'h00;
        default: d = 7'h7F;
      endcase
    end
    return d;
  endfunction

  // advance the model by one VCLK using the inputs the DUT samples at the next edge
  task automatic model_step();
    int htot, vtot;
    if (RST) begin
      e_valid = 1'b1; e_rst = 1'b1; e_nd = 1'b1; e_d = 7'h00; e_sof = 1'b0;
      e_phase = -1; e_pos = -1; e_pal = pal_i;
      m_live = 1'b1; m_phase = 0; m_pos = 0; m_odd = 1'b1; m_pal = pal_i; m_pat = pattern_i;
    end else if (m_live) begin
      e_valid = 1'b1; e_rst = 1'b0;
      e_phase = m_phase; e_pos = m_pos; e_pal = m_pal;
      e_nd  = (m_phase != 0);
      e_sof = (m_phase == 0 && m_pos == 0);
      e_d   = model_d(m_phase, m_pos, m_pal, m_odd, m_pat);
      m_phase++;
      if (m_phase == 4) begin
        m_phase = 0;
        m_pos++;
        htot = m_pal ? 794 : 773;
        vtot = (m_pal ? 313 : 263) - (m_odd ? 0 : 1);
        if (m_pos == htot * vtot) begin
          m_pos = 0;
          m_pal = pal_i;
          m_odd = i480_i ? !m_odd : 1'b1;
        end
        htot = m_pal ? 794 : 773;
        if (m_pos % htot == 0) m_pat = pattern_i;
      end
    end
  endtask

  // compare process: DUT outputs settle mid-cycle, inputs change at posedge+2
  initial forever begin
    @(negedge VCLK);
    if (e_valid) begin
      chk("bus", {23'd0, nDSYNC_o, D_o, sof_o}, {23'd0, e_nd, e_d, e_sof});
      if (e_rst) begin
        chk("reset_vals", {23'd0, nDSYNC_o, D_o, sof_o}, {23'd0, 1'b1, 7'h00, 1'b0});
      end else if (e_phase == 0 && e_pos == 0) begin
        chk("first_nibble", {28'd0, D_o[3:0]}, {28'd0, first_nib});
        chk("first_sof", {31'd0, sof_o}, 32'd1);
      end else if (!e_pal && e_phase == 0 && e_pos == 773 + 10) begin
        chk("csync_v1_h10", {31'd0, D_o[0]}, {31'd0, cs_1_10});
      end else if (!e_pal) begin
        for (int i = 0; i < 16; i++) begin
          if (e_pos == pin_pos[i] && e_phase == pin_ph[i])
            chk($sformatf("pin%0d", i), {25'd0, D_o}, {25'd0, pin_d[i]});
        end
      end
    end
    model_step();
  end

  task automatic wait_slot(input int target);
    int n;
    n = 0;
    while (m_pos < target && n < 80000) begin
      @(posedge VCLK);
      #2;
      n++;
    end
    chk("wait_slot", {31'd0, (m_pos >= target)}, 32'd1);
  endtask

  initial begin
    // pin the model's own timing and colour rules
    chk("model_even_vs_pre", {25'd0, model_d(0, 396, 1'b1, 1'b0, 0) & 7'h08}, 32'h08);
    chk("model_even_vs_fall", {25'd0, model_d(0, 397, 1'b1, 1'b0, 0) & 7'h08}, 32'h00);
    chk("model_even_vs_end", {25'd0, model_d(0, 2778, 1'b1, 1'b0, 0) & 7'h08}, 32'h00);
    chk("model_even_vs_rise", {25'd0, model_d(0, 2779, 1'b1, 1'b0, 0) & 7'h08}, 32'h08);
    chk("model_odd_vs_end", {25'd0, model_d(0, 2318, 1'b0, 1'b1, 0) & 7'h08}, 32'h00);
    chk("model_odd_vs_rise", {25'd0, model_d(0, 2319, 1'b0, 1'b1, 0) & 7'h08}, 32'h08);
    chk("model_bar_y_r", {25'd0, model_d(1, 12576, 1'b0, 1'b1, 0)}, 32'h7F);
    chk("model_bar_y_b", {25'd0, model_d(3, 12576, 1'b0, 1'b1, 0)}, 32'h00);

    // NTSC 240p, bars on line 16, then ramp/checker/white on lines 17..19
    RST = 1'b1; pal_i = 1'b0; i480_i = 1'b0; pattern_i = 2'd0;
    repeat (5) @(posedge VCLK);
    #2 RST = 1'b0;
    wait_slot(16 * 773 + 300);
    pattern_i = 2'd1;
    wait_slot(17 * 773 + 300);
    pattern_i = 2'd2;
    wait_slot(18 * 773 + 300);
    pattern_i = 2'd3;
    wait_slot(19 * 773 + 400);

    // mid-frame reset straight into PAL 480i
    RST = 1'b1; pal_i = 1'b1; i480_i = 1'b1; pattern_i = 2'd2;
    repeat (2) begin
      @(posedge VCLK);
      #2;
    end
    RST = 1'b0;
    wait_slot(2 * 794 + 100);
    pal_i = 1'b0;
    wait_slot(4 * 794);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
